// File: rtl/cv32e40x_obi_tcm_responder_pkg.sv
// Shared types and helpers for the OBI TCM responder: the buffered response
// record, the FIFO depth ceiling and the request legality check.
package cv32e40x_obi_tcm_responder_pkg;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_tcm_resp_t;

  localparam int unsigned TCM_RESP_DEPTH_MAX = 8;
  localparam int unsigned OUTST_W            = $clog2(TCM_RESP_DEPTH_MAX + 1);

  // 33-bit compare so a TCM that ends at the top of the address map does not wrap.
  function automatic logic tcm_req_err(input logic [31:0] addr,
                                       input logic [3:0]  be,
                                       input logic [31:0] base,
                                       input int unsigned words);
    logic [32:0] a33;
    logic [32:0] lo33;
    logic [32:0] hi33;
    a33  = {1'b0, addr};
    lo33 = {1'b0, base};
    hi33 = lo33 + (33'(words) << 2);
    return (a33 < lo33) || (a33 >= hi33) || (be == 4'b0000);
  endfunction

endpackage

// File: rtl/cv32e40x_obi_tcm_responder_if.sv
// OBI data-side bus between a requester (core/interconnect) and the TCM responder.
interface cv32e40x_obi_tcm_responder_if;

  // Address phase: a request transfers on the cycle req_i && gnt_o.
  // Response phase: a response transfers on the cycle rvalid_o && rready_i;
  // while rvalid_o && !rready_i the responder holds rdata_o/err_o stable.
  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic        rready_i;
  logic [31:0] rdata_o;
  logic        err_o;

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i, rready_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i, rready_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );

endinterface

// File: rtl/cv32e40x_resp_fifo.sv
// Small synchronous FIFO for buffered responses; any DEPTH >= 1, including
// non-power-of-two, with explicit pointer wrap.
module cv32e40x_resp_fifo #(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  T                 wdata,
  output T                 rdata,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop = pop && !empty;
  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CNT_W'(DEPTH));
  assign count  = cnt_q;
  assign rdata  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !do_pop) cnt_q <= cnt_q + CNT_W'(1);
      else if (!push && do_pop) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) push |-> !full);

endmodule

// File: rtl/cv32e40x_obi_tcm_responder.sv
// OBI data-side responder in front of a 1-cycle-latency SRAM; in-order responses
// with bypass on an empty response buffer and bus errors for illegal requests.
module cv32e40x_obi_tcm_responder
  import cv32e40x_obi_tcm_responder_pkg::*;
#(
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 1024,
  localparam int unsigned MEM_AW   = $clog2(MEM_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cv32e40x_obi_tcm_responder_if.slave obi,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [MEM_AW-1:0]     mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i,
  output logic [OUTST_W-1:0]    dbg_outst_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  if (DEPTH < 1 || DEPTH > TCM_RESP_DEPTH_MAX) begin : g_bad_depth
    $error("cv32e40x_obi_tcm_responder: DEPTH out of range 1..8");
  end
  if (MEM_BASE[1:0] != 2'b00) begin : g_bad_base
    $error("cv32e40x_obi_tcm_responder: MEM_BASE must be word aligned");
  end

  logic               pend_q;
  logic               pend_err_q;
  logic               pend_rd_q;
  logic               err_req;
  logic [OUTST_W-1:0] outst;

  obi_tcm_resp_t      live_resp;
  obi_tcm_resp_t      head_resp;
  obi_tcm_resp_t      out_resp;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_empty;
  logic               fifo_full;
  logic [CNT_W-1:0]   fifo_cnt;
  logic               rvalid;

  // Grant is not extended by a same-cycle pop: the slot frees one cycle later.
  assign outst       = OUTST_W'(fifo_cnt) + OUTST_W'(pend_q);
  assign err_req     = tcm_req_err(obi.addr_i, obi.be_i, MEM_BASE, MEM_WORDS);
  assign obi.gnt_o   = rst_n && obi.req_i && (outst < OUTST_W'(DEPTH));
  assign dbg_outst_o = outst;

  assign mem_req_o   = obi.gnt_o && !err_req;
  assign mem_we_o    = obi.gnt_o && obi.we_i;
  assign mem_addr_o  = MEM_AW'((obi.addr_i - MEM_BASE) >> 2);
  assign mem_be_o    = obi.be_i;
  assign mem_wdata_o = obi.wdata_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= 1'b0;
      pend_err_q <= 1'b0;
      pend_rd_q  <= 1'b0;
    end else begin
      pend_q <= obi.gnt_o;
      if (obi.gnt_o) begin
        pend_err_q <= err_req;
        pend_rd_q  <= !obi.we_i && !err_req;
      end
    end
  end

  always_comb begin
    live_resp       = '0;
    live_resp.rdata = pend_rd_q ? mem_rdata_i : 32'h0;
    live_resp.err   = pend_err_q;
  end

  // A buffered head always wins so responses leave in grant order.
  always_comb begin
    out_resp = '0;
    rvalid   = 1'b0;
    if (!fifo_empty) begin
      out_resp = head_resp;
      rvalid   = 1'b1;
    end else if (pend_q) begin
      out_resp = live_resp;
      rvalid   = 1'b1;
    end
  end

  assign fifo_push    = pend_q && !(fifo_empty && obi.rready_i);
  assign fifo_pop     = rvalid && obi.rready_i && !fifo_empty;

  assign obi.rvalid_o = rvalid;
  assign obi.rdata_o  = out_resp.rdata;
  assign obi.err_o    = out_resp.err;

  cv32e40x_resp_fifo #(
    .T     (obi_tcm_resp_t),
    .DEPTH (DEPTH)
  ) u_resp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (live_resp),
    .rdata (head_resp),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_cnt)
  );

  a_gnt_needs_req: assert property (@(posedge clk) disable iff (!rst_n) obi.gnt_o |-> obi.req_i);
  a_outst_bound:   assert property (@(posedge clk) disable iff (!rst_n) outst <= OUTST_W'(DEPTH));
  a_mem_needs_gnt: assert property (@(posedge clk) disable iff (!rst_n) mem_req_o |-> obi.gnt_o);
  a_full_no_pend:  assert property (@(posedge clk) disable iff (!rst_n) fifo_full |-> !pend_q);
  a_resp_stable:   assert property (@(posedge clk) disable iff (!rst_n)
                     (rvalid && !obi.rready_i) |=> (rvalid && $stable(out_resp)));

endmodule

// File: tb/tb_cv32e40x_obi_tcm_responder.sv
// Directed bench for the OBI TCM responder with an SRAM model, a reference
// memory and an in-order response scoreboard.
module tb_cv32e40x_obi_tcm_responder;
  import cv32e40x_obi_tcm_responder_pkg::*;

  localparam int unsigned DEPTH     = 2;
  localparam logic [31:0] MEM_BASE  = 32'h0000_0000;
  localparam int unsigned MEM_WORDS = 1024;
  localparam int unsigned MEM_AW    = $clog2(MEM_WORDS);

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cv32e40x_obi_tcm_responder_if bus ();

  logic                mem_req;
  logic                mem_we;
  logic [MEM_AW-1:0]   mem_addr;
  logic [3:0]          mem_be;
  logic [31:0]         mem_wdata;
  logic [31:0]         mem_rdata;
  logic [OUTST_W-1:0]  dbg_outst;

  cv32e40x_obi_tcm_responder #(
    .DEPTH     (DEPTH),
    .MEM_BASE  (MEM_BASE),
    .MEM_WORDS (MEM_WORDS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .obi         (bus.slave),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_be_o    (mem_be),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .dbg_outst_o (dbg_outst)
  );

  // ---------------- SRAM model ----------------
  logic [31:0] sram    [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];

  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_mis = 0;
  logic [32:0] exp_q[$];   // {err, rdata}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [31:0] a, input logic w,
                                         input logic [3:0] b, input logic [31:0] d);
    logic        e;
    int unsigned word;
    e = ({1'b0, a} < {1'b0, MEM_BASE}) ||
        ({1'b0, a} >= ({1'b0, MEM_BASE} + 33'(4 * MEM_WORDS))) ||
        (b == 4'b0000);
    if (e) return {1'b1, 32'h0};
    word = (a - MEM_BASE) / 4;
    if (w) begin
      for (int i = 0; i < 4; i++)
        if (b[i]) ref_mem[word][8*i +: 8] = d[8*i +: 8];
      return {1'b0, 32'h0};
    end
    return {1'b0, ref_mem[word]};
  endfunction

  logic        hold_q   = 1'b0;
  logic [32:0] hold_val = '0;
  logic [32:0] exp_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_q = 1'b0;
    end else begin
      if (hold_q) begin
        check("hold_rvalid", 32'(bus.rvalid_o), 32'd1);
        check("hold_resp", {bus.rdata_o}, hold_val[31:0]);
        check("hold_err", 32'(bus.err_o), 32'(hold_val[32]));
      end
      if (!bus.rvalid_o) begin
        check("idle_rdata", bus.rdata_o, 32'h0);
        check("idle_err", 32'(bus.err_o), 32'd0);
      end
      if (bus.gnt_o)
        exp_q.push_back(model(bus.addr_i, bus.we_i, bus.be_i, bus.wdata_i));
      if (bus.rvalid_o && bus.rready_i) begin
        if (exp_q.size() == 0) begin
          check("resp_without_grant", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_e = exp_q.pop_front();
          check("resp_rdata", bus.rdata_o, exp_e[31:0]);
          check("resp_err", 32'(bus.err_o), 32'(exp_e[32]));
        end
      end
      hold_q   = bus.rvalid_o && !bus.rready_i;
      hold_val = {bus.err_o, bus.rdata_o};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d);
    bus.req_i   = 1'b1;
    bus.addr_i  = a;
    bus.we_i    = w;
    bus.be_i    = b;
    bus.wdata_i = d;
  endtask

  task automatic idle();
    bus.req_i   = 1'b0;
    bus.addr_i  = '0;
    bus.we_i    = 1'b0;
    bus.be_i    = '0;
    bus.wdata_i = '0;
  endtask

  // Drives a request and waits (bounded) at negedge for its grant; returns at posedge+1.
  task automatic request(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d);
    int k;
    drive(a, w, b, d);
    k = 0;
    @(negedge clk);
    while (!bus.gnt_o && k < 20) begin
      cyc();
      @(negedge clk);
      k++;
    end
    check("gnt_wait", 32'(bus.gnt_o), 32'd1);
    cyc();
    idle();
  endtask

  logic rr_pat [3] = '{1'b1, 1'b0, 1'b1};

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < MEM_WORDS; i++) begin
      sram[i]    = $urandom;
      ref_mem[i] = sram[i];
    end
    mem_rdata    = '0;
    bus.rready_i = 1'b0;
    drive(32'h40, 1'b0, 4'hF, 32'h0);   // request held during reset must not be granted
    @(negedge clk);
    check("rst_gnt", 32'(bus.gnt_o), 32'd0);
    check("rst_rvalid", 32'(bus.rvalid_o), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_rdata", bus.rdata_o, 32'h0);
    check("rst_err", 32'(bus.err_o), 32'd0);
    check("rst_outst", 32'(dbg_outst), 32'd0);
    idle();
    cyc();
    rst_n = 1'b1;
    cyc();

    // Write then read back word 0x10
    bus.rready_i = 1'b1;
    drive(32'h40, 1'b1, 4'hF, 32'h1234_5678);
    @(negedge clk);
    check("wr_gnt", 32'(bus.gnt_o), 32'd1);
    check("wr_mem_req", 32'(mem_req), 32'd1);
    check("wr_mem_we", 32'(mem_we), 32'd1);
    check("wr_mem_addr", 32'(mem_addr), 32'h10);
    check("wr_mem_wdata", mem_wdata, 32'h1234_5678);
    cyc();
    drive(32'h40, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    check("rd_gnt", 32'(bus.gnt_o), 32'd1);
    check("rd_mem_we", 32'(mem_we), 32'd0);
    cyc();
    idle();
    @(negedge clk);
    check("rd_rvalid", 32'(bus.rvalid_o), 32'd1);
    check("rd_rdata", bus.rdata_o, 32'h1234_5678);
    check("rd_err", 32'(bus.err_o), 32'd0);
    cyc();

    // Preload four words, then back-to-back reads under back-pressure
    for (int i = 0; i < 4; i++) request(32'h100 + 32'(4 * i), 1'b1, 4'hF, 32'hC0DE_0000 + 32'(i));
    cyc();
    bus.rready_i = 1'b0;
    drive(32'h100, 1'b0, 4'hF, 32'h0);
    @(negedge clk); check("bp_gnt0", 32'(bus.gnt_o), 32'd1);
    cyc();
    drive(32'h104, 1'b0, 4'hF, 32'h0);
    @(negedge clk); check("bp_gnt1", 32'(bus.gnt_o), 32'd1);
    cyc();
    drive(32'h108, 1'b0, 4'hF, 32'h0);
    @(negedge clk); check("bp_gnt2_blocked", 32'(bus.gnt_o), 32'd0);
    check("bp_head", bus.rdata_o, 32'hC0DE_0000);
    cyc();
    @(negedge clk); check("bp_gnt3_blocked", 32'(bus.gnt_o), 32'd0);
    check("bp_outst", 32'(dbg_outst), 32'd2);
    cyc();
    bus.rready_i = 1'b1;
    @(negedge clk); check("bp_gnt_pop_cycle", 32'(bus.gnt_o), 32'd0);
    cyc();
    @(negedge clk); check("bp_gnt_resume", 32'(bus.gnt_o), 32'd1);
    cyc();
    drive(32'h10C, 1'b0, 4'hF, 32'h0);
    @(negedge clk); check("bp_gnt_last", 32'(bus.gnt_o), 32'd1);
    cyc();
    idle();
    repeat (4) cyc();

    // Out-of-range read
    drive(32'h1000, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    check("oor_gnt", 32'(bus.gnt_o), 32'd1);
    check("oor_mem_req", 32'(mem_req), 32'd0);
    cyc();
    idle();
    @(negedge clk);
    check("oor_rvalid", 32'(bus.rvalid_o), 32'd1);
    check("oor_err", 32'(bus.err_o), 32'd1);
    check("oor_rdata", bus.rdata_o, 32'h0);
    cyc();

    // Zero byte-enable write leaves memory untouched
    request(32'h8, 1'b1, 4'hF, 32'hA5A5_0008);
    drive(32'h8, 1'b1, 4'h0, 32'hDEAD_BEEF);
    @(negedge clk);
    check("be0_gnt", 32'(bus.gnt_o), 32'd1);
    check("be0_mem_req", 32'(mem_req), 32'd0);
    cyc();
    idle();
    @(negedge clk);
    check("be0_err", 32'(bus.err_o), 32'd1);
    cyc();
    request(32'h8, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    check("be0_readback", bus.rdata_o, 32'hA5A5_0008);
    cyc();

    // Interleaved good read / error write / good read with rready toggling
    for (int i = 0; i < 3; i++) begin
      bus.rready_i = rr_pat[i];
      case (i)
        0:       request(32'h40, 1'b0, 4'hF, 32'h0);
        1:       request(32'h2000, 1'b1, 4'hF, 32'h5555_AAAA);
        default: request(32'h8, 1'b0, 4'hF, 32'h0);
      endcase
    end
    bus.rready_i = 1'b1;
    repeat (5) cyc();
    check("mix_drained", 32'(exp_q.size()), 32'd0);

    // Reset with two responses buffered
    bus.rready_i = 1'b0;
    drive(32'h100, 1'b0, 4'hF, 32'h0);
    @(negedge clk); cyc();
    drive(32'h104, 1'b0, 4'hF, 32'h0);
    @(negedge clk); cyc();
    idle();
    cyc();
    @(negedge clk);
    check("pre_rst_outst", 32'(dbg_outst), 32'd2);
    check("pre_rst_rvalid", 32'(bus.rvalid_o), 32'd1);
    cyc();
    rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid", 32'(bus.rvalid_o), 32'd0);
    check("mid_rst_err", 32'(bus.err_o), 32'd0);
    exp_q.delete();
    cyc();
    cyc();
    rst_n = 1'b1;
    bus.rready_i = 1'b1;
    cyc();
    check("post_rst_outst", 32'(dbg_outst), 32'd0);
    drive(32'h104, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    check("post_rst_gnt", 32'(bus.gnt_o), 32'd1);
    cyc();
    idle();
    repeat (4) cyc();

    // Random single-beat traffic with random back-pressure
    for (int i = 0; i < 40; i++) begin
      bus.rready_i = ($urandom_range(0, 3) != 0);
      drive(32'($urandom_range(0, 1100)) << 2, 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), $urandom);
      @(negedge clk);
      cyc();
    end
    idle();
    bus.rready_i = 1'b1;
    repeat (6) cyc();
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
